// File: rtl/vec_shift_pkg.sv
// vec_shift_pkg: shared op type, saturation bounds and default sizes for the vector shifter
package vec_shift_pkg;
  localparam int LANES_DEF   = 4;
  localparam int DATA_W_DEF  = 16;
  localparam int SHIFT_W_DEF = 5;
  typedef struct packed {
    logic dir;
    logic round;
    logic sat;
  } shift_op_t;
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/lane_shift.sv
// lane_shift: one lane's coarse shift / round-bit / overflow detect and the later increment / clamp
module lane_shift
  import vec_shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic [DATA_W-1:0]  x_i,
  input  logic [SHIFT_W-1:0] s_i,
  input  shift_op_t          op_i,
  output logic [DATA_W-1:0]  coarse_o,
  output logic               rb_o,
  output logic               ovf_o,
  input  logic [DATA_W-1:0]  x_q_i,
  input  logic [DATA_W-1:0]  coarse_q_i,
  input  logic               rb_q_i,
  input  logic               ovf_q_i,
  input  shift_op_t          op_q_i,
  output logic [DATA_W-1:0]  res_o,
  output logic               ovf_flag_o
);
  localparam logic [63:0] MAX64 = sat_max(DATA_W);
  localparam logic [63:0] MIN64 = sat_min(DATA_W);
  localparam logic [DATA_W-1:0] MAX_V = MAX64[DATA_W-1:0];
  localparam logic [DATA_W-1:0] MIN_V = MIN64[DATA_W-1:0];
  int sc;
  logic signed [DATA_W-1:0] xs, rs, pre;
  logic [2*DATA_W-1:0] wide;
  // Amounts at or beyond the lane width behave exactly like a shift of DATA_W, so clamp first.
  always_comb begin
    sc = (int'(s_i) >= DATA_W) ? DATA_W : int'(s_i);
    xs = x_i;
    rs = xs >>> sc;
    pre = xs >>> ((sc == 0) ? 0 : sc - 1);
    wide = {{DATA_W{x_i[DATA_W-1]}}, x_i} << sc;
    coarse_o = op_i.dir ? rs : wide[DATA_W-1:0];
    rb_o = op_i.dir && op_i.round && (sc != 0) && pre[0];
    ovf_o = !op_i.dir && (wide[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){x_i[DATA_W-1]}});
  end
  // The rounding increment can never carry out of range, so only overflowing left shifts clamp.
  always_comb begin
    ovf_flag_o = ovf_q_i;
    res_o = (ovf_q_i && op_q_i.sat) ? (x_q_i[DATA_W-1] ? MIN_V : MAX_V)
                                    : coarse_q_i + {{(DATA_W-1){1'b0}}, rb_q_i};
  end
endmodule

// File: rtl/vec_shift_unit.sv
// vec_shift_unit: two-stage pipelined multi-lane power-of-two scaler with valid/ready handshake
module vec_shift_unit
  import vec_shift_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [LANES*SHIFT_W-1:0]  in_shamt,
  input  logic                      in_dir,
  input  logic                      in_round,
  input  logic                      in_sat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_ovf
);
  logic en;
  shift_op_t op_d, s1_op_q;
  logic s1_v_q;
  logic [LANES-1:0][DATA_W-1:0] s1_x_q, s1_c_q, c_d, res_d;
  logic [LANES-1:0] s1_rb_q, s1_ovf_q, rb_d, ovf_d, flag_d;
  logic out_valid_q;
  logic [LANES*DATA_W-1:0] out_data_q;
  logic [LANES-1:0] out_ovf_q;
  assign en = !out_valid_q || out_ready;
  assign in_ready = en;
  assign op_d = {in_dir, in_round, in_sat};
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_ovf = out_ovf_q;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_shift #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W)) u_lane (
      .x_i        (in_data[i*DATA_W +: DATA_W]),
      .s_i        (in_shamt[i*SHIFT_W +: SHIFT_W]),
      .op_i       (op_d),
      .coarse_o   (c_d[i]),
      .rb_o       (rb_d[i]),
      .ovf_o      (ovf_d[i]),
      .x_q_i      (s1_x_q[i]),
      .coarse_q_i (s1_c_q[i]),
      .rb_q_i     (s1_rb_q[i]),
      .ovf_q_i    (s1_ovf_q[i]),
      .op_q_i     (s1_op_q),
      .res_o      (res_d[i]),
      .ovf_flag_o (flag_d[i])
    );
  end
  // S1: capture operands and the coarse shift whenever the pipeline is free to advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      s1_op_q  <= '0;
      s1_x_q   <= '0;
      s1_c_q   <= '0;
      s1_rb_q  <= '0;
      s1_ovf_q <= '0;
    end else if (en) begin
      s1_v_q   <= in_valid;
      s1_op_q  <= op_d;
      s1_x_q   <= in_data;
      s1_c_q   <= c_d;
      s1_rb_q  <= rb_d;
      s1_ovf_q <= ovf_d;
    end
  end
  // S2: output registers hold their beat while stalled; bubbles leave the last data in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= '0;
    end else if (en) begin
      out_valid_q <= s1_v_q;
      if (s1_v_q) begin
        out_data_q <= res_d;
        out_ovf_q  <= flag_d;
      end
    end
  end
endmodule

// File: tb/tb_vec_shift_unit.sv
// tb_vec_shift_unit: randomized scoreboard bench for vec_shift_unit against an arithmetic model
module tb_vec_shift_unit;
  localparam int L = 4, W = 16, SW = 5;
  logic clk = 0, rst_n = 1;
  logic in_valid = 0, in_dir = 0, in_round = 0, in_sat = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [L*W-1:0] in_data = '0, out_data;
  logic [L*SW-1:0] in_shamt = '0;
  logic [L-1:0] out_ovf;
  int checks = 0, errors = 0;
  int rmode = 0, rcnt = 0;
  typedef struct { logic [L*W-1:0] d; logic [L-1:0] o; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic prev_stall = 0;
  logic [L*W-1:0] prev_d;
  logic [L-1:0] prev_o;

  always #5 clk = ~clk;

  vec_shift_unit #(.LANES(L), .DATA_W(W), .SHIFT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_dir(in_dir), .in_round(in_round),
    .in_sat(in_sat), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scalar reference: {ovf, result} from plain signed arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] x, input int s, input bit dir, input bit rnd, input bit sat);
    longint v, p;
    logic [W-1:0] r;
    bit ovf;
    v = longint'($signed(x));
    ovf = 0;
    if (dir) begin
      if (rnd && s != 0) p = (v + (longint'(1) <<< (s - 1))) >>> s;
      else p = v >>> s;
      r = p[W-1:0];
    end else begin
      p = v <<< s;
      ovf = (p > 32767) || (p < -32768);
      r = p[W-1:0];
      if (ovf && sat) r = (v >= 0) ? 16'h7FFF : 16'h8000;
    end
    return {ovf, r};
  endfunction

  function automatic exp_t beat_exp(input logic [L*W-1:0] d, input logic [L*SW-1:0] s, input bit dir, input bit rnd, input bit sat);
    exp_t b;
    logic [W:0] m;
    for (int i = 0; i < L; i++) begin
      m = model(d[i*W +: W], int'(s[i*SW +: SW]), dir, rnd, sat);
      b.d[i*W +: W] = m[W-1:0];
      b.o[i] = m[W];
    end
    return b;
  endfunction

  function automatic logic [L*W-1:0] pk(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [L*SW-1:0] pks(input logic [SW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [W-1:0] rnd_x();
    logic [W-1:0] t [6];
    t = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h4000};
    return ($urandom_range(0, 3) == 0) ? t[$urandom_range(0, 5)] : W'($urandom);
  endfunction

  // Downstream ready pattern: held by the main flow, toggled every 3 cycles, or random.
  always @(posedge clk) begin
    #1;
    rcnt++;
    if (rmode == 1 && rcnt % 3 == 0) out_ready = !out_ready;
    else if (rmode == 2) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Compare process: handshake rule, stall hold, and scoreboard on every output transfer.
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_d);
        chk("hold_ovf", out_ovf, prev_o);
      end
      if (in_valid && in_ready) sb.push_back(beat_exp(in_data, in_shamt, in_dir, in_round, in_sat));
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_ovf", out_ovf, e.o);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_o = out_ovf;
    end
  end

  task automatic send(input logic [L*W-1:0] d, input logic [L*SW-1:0] s, input bit dir, input bit rnd, input bit sat);
    bit acc;
    acc = 0;
    in_valid = 1; in_data = d; in_shamt = s; in_dir = dir; in_round = rnd; in_sat = sat;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    chk("send_accept", acc, 1);
  endtask

  task automatic idle();
    in_valid = 0;
    in_data = {L{rnd_x()}};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic lat_check(input string tag);
    chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk);
    #1;
    chk({tag, "_lat2"}, out_valid, 1);
  endtask

  initial begin
    #2 rst_n = 0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("pin_r", model(16'hFFFB, 1, 1, 0, 0), 17'h0FFFD);
    chk("pin_r_rnd", model(16'hFFFB, 1, 1, 1, 0), 17'h0FFFE);
    chk("pin_r_rnd7", model(16'h0007, 2, 1, 1, 0), 17'h00002);
    chk("pin_l_sat", model(16'h4000, 1, 0, 0, 1), 17'h17FFF);
    chk("pin_l_wrap", model(16'h4000, 1, 0, 0, 0), 17'h18000);
    chk("pin_l_neg", model(16'hC000, 1, 0, 0, 1), 17'h08000);
    chk("pin_r_big", model(16'h8001, 20, 1, 0, 0), 17'h0FFFF);
    chk("pin_r_big_rnd", model(16'h8001, 20, 1, 1, 0), 17'h00000);
    chk("pin_l16", model(16'h0001, 16, 0, 0, 1), 17'h17FFF);
    chk("pin_l16_zero", model(16'h0000, 16, 0, 0, 1), 17'h00000);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1;
    // Directed beats from the boundary cases, back to back at full rate.
    send(pk(16'hFFFB, 16'h0007, 16'h8001, 16'h1234), pks(1, 2, 20, 0), 1, 0, 0);
    send(pk(16'hFFFB, 16'h0007, 16'h8001, 16'h1234), pks(1, 2, 20, 0), 1, 1, 0);
    send(pk(16'h4000, 16'h0001, 16'h0000, 16'hC000), pks(1, 16, 16, 1), 0, 0, 1);
    send(pk(16'h4000, 16'h0001, 16'h0000, 16'hC000), pks(1, 16, 16, 1), 0, 0, 0);
    idle();
    drain();
    // Mixed lanes in one beat, with exact latency.
    send(pk(16'h1234, 16'hFFFB, 16'h0007, 16'h8001), pks(3, 1, 0, 20), 1, 1, 0);
    idle();
    lat_check("mixed_r");
    drain();
    send(pk(16'h00FF, 16'hFF00, 16'h0003, 16'h7FFF), pks(8, 8, 31, 0), 0, 0, 1);
    idle();
    lat_check("mixed_l");
    drain();
    // Backpressure: 8 beats while ready toggles every third cycle.
    rmode = 1;
    for (int b = 0; b < 8; b++)
      send({rnd_x(), rnd_x(), rnd_x(), rnd_x()}, L*SW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    idle();
    drain();
    // Random traffic with random downstream stalls and input gaps.
    rmode = 2;
    for (int b = 0; b < 300; b++) begin
      send({rnd_x(), rnd_x(), rnd_x(), rnd_x()}, L*SW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
    end
    idle();
    rmode = 0;
    out_ready = 1;
    drain();
    // Reset with two beats in flight and the output stalled.
    out_ready = 0;
    send(pk(16'h0101, 16'h0202, 16'h0303, 16'h0404), pks(1, 2, 3, 4), 0, 0, 0);
    send(pk(16'h1111, 16'h2222, 16'h3333, 16'h4444), pks(1, 1, 1, 1), 1, 0, 0);
    idle();
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 0;
    sb.delete();
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ovf", out_ovf, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_after_valid", out_valid, 0);
    out_ready = 1;
    send(pk(16'hFFFB, 16'h4000, 16'h0007, 16'h8001), pks(1, 1, 2, 20), 0, 0, 1);
    idle();
    lat_check("post_rst");
    drain();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
